// File: rtl/cnt_step_decoder.sv
// Receive-side decoder for a modulo counter's value stream: infers count direction and flags wraps, holds and illegal steps.
// Optional range check on cnt_in enabled by defining CNT_DEC_RANGE_CHK_EN.
module cnt_step_decoder #(
  parameter int W     = 10,
  parameter int MOD   = 1000,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_vld,
  input  logic [W-1:0]     cnt_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             dir_up,
  output logic             hold,
  output logic             wrap,
  output logic             dir_chg,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             range_err
);

  typedef enum logic [1:0] {IDLE, SYNC, UP, DOWN} state_t;

  localparam logic [W-1:0] LAST  = W'(MOD - 1);
  localparam logic [W:0]   MOD_X = (W + 1)'(MOD);

  state_t           state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic             hold_q, hold_d;
  logic             wrap_q, wrap_d;
  logic             dir_chg_q, dir_chg_d;
  logic             step_err_q, step_err_d;
  logic             range_err_q, range_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [W:0] inc_v, dec_v;
  logic       fwd, bwd, same, wrap_step, out_of_range, err_event;

  // Neighbours are computed one bit wider so an out-of-range prev cannot alias via overflow.
  always_comb begin
    inc_v     = (prev_q == LAST) ? '0 : {1'b0, prev_q} + 1'b1;
    dec_v     = (prev_q == '0) ? {1'b0, LAST} : {1'b0, prev_q} - 1'b1;
    fwd       = (inc_v == {1'b0, cnt_in});
    bwd       = (dec_v == {1'b0, cnt_in});
    same      = (cnt_in == prev_q);
    wrap_step = ((prev_q == LAST) && (cnt_in == '0)) ||
                ((prev_q == '0) && (cnt_in == LAST));
`ifdef CNT_DEC_RANGE_CHK_EN
    out_of_range = ({1'b0, cnt_in} >= MOD_X);
`else
    out_of_range = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    hold_d      = 1'b0;
    wrap_d      = 1'b0;
    dir_chg_d   = 1'b0;
    step_err_d  = 1'b0;
    range_err_d = 1'b0;
    if (cnt_vld) begin
      if (out_of_range) begin
        range_err_d = 1'b1;
        step_err_d  = 1'b1;
        state_d     = SYNC;
      end else begin
        prev_d = cnt_in;
        unique case (state_q)
          IDLE: state_d = SYNC;
          SYNC: begin
            if (fwd) begin
              state_d = UP;
              wrap_d  = wrap_step;
            end else if (bwd) begin
              state_d = DOWN;
              wrap_d  = wrap_step;
            end else if (same) hold_d = 1'b1;
            else step_err_d = 1'b1;
          end
          UP: begin
            if (fwd) wrap_d = wrap_step;
            else if (bwd) begin
              state_d   = DOWN;
              dir_chg_d = 1'b1;
              wrap_d    = wrap_step;
            end else if (same) hold_d = 1'b1;
            else begin
              step_err_d = 1'b1;
              state_d    = SYNC;
            end
          end
          DOWN: begin
            if (bwd) wrap_d = wrap_step;
            else if (fwd) begin
              state_d   = UP;
              dir_chg_d = 1'b1;
              wrap_d    = wrap_step;
            end else if (same) hold_d = 1'b1;
            else begin
              step_err_d = 1'b1;
              state_d    = SYNC;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    err_event = step_err_d;
    err_cnt_d = err_cnt_q;
    if (clr_err) err_cnt_d = '0;
    else if (err_event && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      hold_q      <= 1'b0;
      wrap_q      <= 1'b0;
      dir_chg_q   <= 1'b0;
      step_err_q  <= 1'b0;
      range_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      hold_q      <= hold_d;
      wrap_q      <= wrap_d;
      dir_chg_q   <= dir_chg_d;
      step_err_q  <= step_err_d;
      range_err_q <= range_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == UP) || (state_q == DOWN);
  assign dir_up    = (state_q == UP);
  assign hold      = hold_q;
  assign wrap      = wrap_q;
  assign dir_chg   = dir_chg_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;
  assign range_err = range_err_q;

endmodule
